sync_fifo_flex: RTL and testbench
=================================

// Module: sync_fifo_flex
//
// PURPOSE
//  Parametrised synchronous FIFO; successor to the fixed-behaviour sync_fifo.
//  Adds a selectable read mode (registered or first-word-fall-through), programmable
//  almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
//  Buffers event words between the DVS event encoder and the readout/serialiser path,
//  all on one clock domain.
//
// PARAMETERS
//  DWIDTH     64        data word width, >= 1
//  DEPTH      16        number of entries; power of two, >= 2
//  FWFT       1         1 = first-word-fall-through read; 0 = registered read, 1-cycle latency
//  AF_THRESH  DEPTH-2   almost_full asserts when numel >= AF_THRESH; range 1..DEPTH
//  AE_THRESH  2         almost_empty asserts when numel <= AE_THRESH; range 0..DEPTH-1
//
// PORTS
//  clk           in   1                 clock; all logic on the rising edge
//  rst           in   1                 synchronous, active-high reset
//  wr_en         in   1                 write request
//  wdata         in   DWIDTH            write data
//  rd_en         in   1                 read request (FWFT: pop/acknowledge of the head word)
//  rdata         out  DWIDTH            read data
//  empty         out  1                 numel == 0
//  full          out  1                 numel == DEPTH
//  almost_empty  out  1                 numel <= AE_THRESH
//  almost_full   out  1                 numel >= AF_THRESH
//  numel         out  $clog2(DEPTH)+1   current occupancy
//  overflow      out  1                 sticky: a write was rejected
//  underflow     out  1                 sticky: a read was rejected
//  clr_err       in   1                 clears overflow and underflow
//  hwm           out  $clog2(DEPTH)+1   high-water mark (SYNC_FIFO_HWM_EN only)
//
// BEHAVIOUR
//  - Interface: one clock, clk. Reset is synchronous and active-high, port rst.
//  - Reset (rst=1 at a clk edge):
//    - wr_ptr = rd_ptr = 0 and numel = 0.
//    - empty = 1, almost_empty = 1; full = 0, almost_full = 0.
//    - overflow = underflow = 0; rdata = 0; hwm = 0.
//    - Storage contents are not cleared. Reset mid-operation discards all queued words.
//  - Accept rules:
//    - rd_acc = rd_en && !empty.
//    - wr_acc = wr_en && (!full || rd_acc). Full with a read in the same cycle accepts both.
//    - Empty with rd_en and wr_en: the write is accepted and the read is rejected (no bypass).
//  - numel_next = numel + wr_acc - rd_acc. Flags are registered from numel_next, so they
//    always agree with numel in the same cycle.
//  - Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
//  - Registered read (FWFT=0): on rd_acc, rdata <= mem[rd_ptr], valid the next cycle.
//    Otherwise rdata holds its last value.
//  - FWFT read (FWFT=1): rdata = mem[rd_ptr]; it is valid whenever empty = 0.
//    - rd_acc advances to the next word on the following cycle.
//    - A write into an empty FIFO is visible one cycle later, when empty drops.
//  - Error flags:
//    - overflow sets when wr_en && !wr_acc.
//    - underflow sets when rd_en && empty.
//    - Both hold until clr_err or rst. Set in the same cycle as clr_err wins.
//    - Rejected operations change no state other than the error flags.
//  - Both operations of a simultaneous accepted read and write complete in one cycle;
//    numel is unchanged.
//
// CONFIGURATION
//  - SYNC_FIFO_HWM_EN defined: hwm is a registered maximum of numel.
//    It updates when numel_next > hwm and clears only on rst.
//  - SYNC_FIFO_HWM_EN undefined: the hwm port is still present and tied to 0. No register
//    is inferred.
//
// STRUCTURE
//  - sync_fifo_pkg: ptr_t/cnt_t width helper functions, the rd_mode_e enum
//    {RD_REG, RD_FWFT}, and a threshold range-check function used in elaboration
//    assertions.
//  - Sub-module sync_fifo_mem: DEPTH x DWIDTH register array with one write port and
//    one asynchronous read port. It is instantiated once; the control/flag logic stays
//    in sync_fifo_flex.
//
// TESTING (DWIDTH=64, DEPTH=16, AF_THRESH=14, AE_THRESH=2)
//  1. rst for 2 cycles then release -> empty=1, almost_empty=1, full=0, numel=0,
//     overflow=0, underflow=0.
//  2. Write 16 words 0x...00..0x...0F -> full=1, numel=16; almost_full rises at the 14th
//     write. A 17th write sets overflow=1 and leaves numel=16.
//  3. From full, rd_en+wr_en 0xAA together -> numel stays 16. Draining returns
//     0x01..0x0F then 0xAA, in order.
//  4. FWFT=1: write 0x5 into empty -> the next cycle gives empty=0 and rdata=0x5 with no
//     rd_en. rd_en on the empty FIFO sets underflow; clr_err clears it one cycle later.
//  5. FWFT=0: write 3 words and read 3 -> each rdata is valid 1 cycle after rd_en.
//     20 write/read cycles wrap the pointers with data intact.
//  6. SYNC_FIFO_HWM_EN: fill to 9 and drain to 0 -> hwm=9. rst mid-fill -> numel=0,
//     hwm=0, empty=1.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo family.
package sync_fifo_pkg;

    // How the read port presents data.
    typedef enum logic {
        RD_REG  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    // Pointer width: enough bits to index DEPTH entries.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width: one extra bit so the value DEPTH is representable.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Geometry and threshold legality, checked at elaboration.
    function automatic bit thresh_ok(input int unsigned depth,
                                     input int unsigned af_thresh,
                                     input int unsigned ae_thresh);
        bit depth_ok;
        depth_ok = (depth >= 2) && ((depth & (depth - 1)) == 0);
        return depth_ok && (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DWIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [ptr_w(DEPTH)-1:0]    waddr,
    input  logic [DWIDTH-1:0]          wdata,
    input  logic [ptr_w(DEPTH)-1:0]    raddr,
    output logic [DWIDTH-1:0]          rdata
);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Asynchronous read port.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional feature macro: SYNC_FIFO_HWM_EN enables the high-water-mark register;
// without it the hwm port reads 0.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH    = 64,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FWFT      = 1,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DWIDTH-1:0]       wdata,
    input  logic                    rd_en,
    output logic [DWIDTH-1:0]       rdata,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [cnt_w(DEPTH)-1:0] numel,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err,
    output logic [cnt_w(DEPTH)-1:0] hwm
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);
    localparam rd_mode_e RdMode = (FWFT != 0) ? RD_FWFT : RD_REG;

    if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_cfg
        $error("sync_fifo_flex: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     numel_q, numel_d;
    logic              empty_q, full_q, aempty_q, afull_q;
    logic              overflow_q, underflow_q;
    logic              overflow_d, underflow_d;
    logic              rd_acc, wr_acc;
    logic [DWIDTH-1:0] mem_rdata;

    // Accept decisions and next occupancy; a read frees the slot a full-FIFO write needs.
    always_comb begin
        rd_acc  = rd_en && !empty_q;
        wr_acc  = wr_en && (!full_q || rd_acc);
        numel_d = numel_q;
        if (wr_acc && !rd_acc) begin
            numel_d = numel_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            numel_d = numel_q - CW'(1);
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes priority over the clear.
    always_comb begin
        overflow_d  = (overflow_q && !clr_err) || (wr_en && !wr_acc);
        underflow_d = (underflow_q && !clr_err) || (rd_en && empty_q);
    end

    // Pointers, occupancy and status flags, all registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            numel_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            numel_q  <= numel_d;
            empty_q  <= (numel_d == '0);
            full_q   <= (numel_d == CW'(DEPTH));
            aempty_q <= (numel_d <= CW'(AE_THRESH));
            afull_q  <= (numel_d >= CW'(AF_THRESH));
        end
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    if (RdMode == RD_FWFT) begin : g_fwft
        // Head word shown directly; forced to 0 while empty so reset reads back 0.
        always_comb begin
            rdata = empty_q ? '0 : mem_rdata;
        end
    end else begin : g_reg
        logic [DWIDTH-1:0] rdata_q;

        // Registered read: capture the head word on an accepted read, otherwise hold.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (rd_acc) begin
                rdata_q <= mem_rdata;
            end
        end

        always_comb begin
            rdata = rdata_q;
        end
    end

`ifdef SYNC_FIFO_HWM_EN
    logic [CW-1:0] hwm_q;

    // High-water mark: largest occupancy seen since the last reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm_q <= '0;
        end else if (numel_d > hwm_q) begin
            hwm_q <= numel_d;
        end
    end

    always_comb begin
        hwm = hwm_q;
    end
`else
    always_comb begin
        hwm = '0;
    end
`endif

    // Output drive.
    always_comb begin
        empty        = empty_q;
        full         = full_q;
        almost_empty = aempty_q;
        almost_full  = afull_q;
        numel        = numel_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: one FWFT and one registered-read instance share stimulus;
// a queue-based model is compared every cycle, with literal checks at key points.
module tb_sync_fifo_flex;

    localparam int unsigned DW = 64;
    localparam int unsigned DP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;

    logic [DW-1:0] rdata_f, rdata_r;
    logic          empty_f, full_f, ae_f, af_f, ovf_f, unf_f;
    logic          empty_r, full_r, ae_r, af_r, ovf_r, unf_r;
    logic [4:0]    numel_f, numel_r, hwm_f, hwm_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_flex #(
        .DWIDTH(DW), .DEPTH(DP), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)
    ) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata_f), .empty(empty_f), .full(full_f), .almost_empty(ae_f),
        .almost_full(af_f), .numel(numel_f), .overflow(ovf_f), .underflow(unf_f),
        .clr_err(clr_err), .hwm(hwm_f)
    );

    sync_fifo_flex #(
        .DWIDTH(DW), .DEPTH(DP), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)
    ) u_reg (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata_r), .empty(empty_r), .full(full_r), .almost_empty(ae_r),
        .almost_full(af_r), .numel(numel_r), .overflow(ovf_r), .underflow(unf_r),
        .clr_err(clr_err), .hwm(hwm_r)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_q[$];
    bit            m_valid = 1'b0;
    bit            m_ovf, m_unf;
    logic [DW-1:0] m_regrd;
    int            m_hwm;

    always @(posedge clk) begin
        bit ra, wa, was_empty;
        if (rst) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_regrd = '0;
            m_hwm   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            was_empty = (m_q.size() == 0);
            ra = rd_en && !was_empty;
            wa = wr_en && ((m_q.size() != DP) || ra);
            if (ra) m_regrd = m_q.pop_front();
            if (wa) m_q.push_back(wdata);
            m_ovf = (m_ovf && !clr_err) || (wr_en && !wa);
            m_unf = (m_unf && !clr_err) || (rd_en && was_empty);
            if (m_q.size() > m_hwm) m_hwm = m_q.size();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int   sz;
        logic [4:0] exp_hwm;
        if (m_valid) begin
            sz = m_q.size();
`ifdef SYNC_FIFO_HWM_EN
            exp_hwm = 5'(m_hwm);
`else
            exp_hwm = 5'd0;
`endif
            chk("numel_f", 64'(numel_f), 64'(sz));
            chk("numel_r", 64'(numel_r), 64'(sz));
            chk("empty_f", 64'(empty_f), 64'(sz == 0));
            chk("empty_r", 64'(empty_r), 64'(sz == 0));
            chk("full_f", 64'(full_f), 64'(sz == DP));
            chk("full_r", 64'(full_r), 64'(sz == DP));
            chk("aempty_f", 64'(ae_f), 64'(sz <= 2));
            chk("aempty_r", 64'(ae_r), 64'(sz <= 2));
            chk("afull_f", 64'(af_f), 64'(sz >= 14));
            chk("afull_r", 64'(af_r), 64'(sz >= 14));
            chk("ovf_f", 64'(ovf_f), 64'(m_ovf));
            chk("ovf_r", 64'(ovf_r), 64'(m_ovf));
            chk("unf_f", 64'(unf_f), 64'(m_unf));
            chk("unf_r", 64'(unf_r), 64'(m_unf));
            chk("hwm_f", 64'(hwm_f), 64'(exp_hwm));
            chk("hwm_r", 64'(hwm_r), 64'(exp_hwm));
            chk("rdata_r", rdata_r, m_regrd);
            if (sz != 0) chk("rdata_f", rdata_f, m_q[0]);
        end
    end

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        wr_en   = w;
        wdata   = d;
        rd_en   = r;
        clr_err = c;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_w;
        logic [4:0]    exp_hwm9;

        // 1. reset
        rst = 1'b1;
        drive(0, '0, 0, 0);
        drive(0, '0, 0, 0);
        rst = 1'b0;
        drive(0, '0, 0, 0);
        chk("rst_empty", 64'(empty_f), 64'd1);
        chk("rst_aempty", 64'(ae_r), 64'd1);
        chk("rst_full", 64'(full_f), 64'd0);
        chk("rst_numel", 64'(numel_r), 64'd0);
        chk("rst_ovf", 64'(ovf_f), 64'd0);
        chk("rst_unf", 64'(unf_r), 64'd0);
        chk("rst_rdata_r", rdata_r, 64'd0);

        // 2. fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            drive(1, DW'(i), 0, 0);
            if (i == 12) chk("af_13", 64'(af_f), 64'd0);
            if (i == 13) chk("af_14", 64'(af_f), 64'd1);
        end
        chk("fill_full", 64'(full_f), 64'd1);
        chk("fill_numel", 64'(numel_f), 64'd16);
        drive(1, 64'h10, 0, 0);
        chk("ovf_set", 64'(ovf_r), 64'd1);
        chk("ovf_numel", 64'(numel_r), 64'd16);

        // 3. simultaneous read+write while full, then drain in order
        drive(1, 64'hAA, 1, 0);
        chk("rw_full_numel", 64'(numel_f), 64'd16);
        chk("rw_full_rdata_r", rdata_r, 64'd0);
        for (int k = 0; k < 16; k++) begin
            exp_w = (k < 15) ? DW'(k + 1) : 64'hAA;
            chk("drain_f", rdata_f, exp_w);
            drive(0, '0, 1, 0);
            chk("drain_r", rdata_r, exp_w);
        end
        chk("drained_empty", 64'(empty_f), 64'd1);
        drive(0, '0, 0, 1);
        chk("ovf_clr", 64'(ovf_f), 64'd0);

        // 4. FWFT visibility, underflow and error-clear behaviour
        drive(1, 64'h5, 0, 0);
        chk("fwft_empty", 64'(empty_f), 64'd0);
        chk("fwft_rdata", rdata_f, 64'h5);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);
        chk("unf_set", 64'(unf_f), 64'd1);
        drive(0, '0, 0, 1);
        chk("unf_clr", 64'(unf_f), 64'd0);
        drive(0, '0, 1, 1);
        chk("unf_set_wins", 64'(unf_r), 64'd1);
        drive(0, '0, 0, 1);
        drive(1, 64'h77, 1, 0);
        chk("empty_rw_numel", 64'(numel_f), 64'd1);
        chk("empty_rw_unf", 64'(unf_f), 64'd1);
        drive(0, '0, 1, 1);
        chk("empty_rw_pop", 64'(rdata_r), 64'h77);

        // 5. registered read latency and pointer wrap
        for (int i = 0; i < 3; i++) drive(1, 64'h100 + DW'(i), 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, 0);
            chk("reg_lat", rdata_r, 64'h100 + DW'(i));
        end
        drive(1, 64'h200, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            drive(1, 64'h200 + DW'(i), 1, 0);
            chk("wrap_r", rdata_r, 64'h200 + DW'(i - 1));
            chk("wrap_f", rdata_f, 64'h200 + DW'(i));
        end
        drive(0, '0, 1, 0);
        chk("wrap_last", rdata_r, 64'h214);

        // 6. high-water mark and mid-fill reset
        rst = 1'b1;
        drive(0, '0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) drive(1, 64'h300 + DW'(i), 0, 0);
        for (int i = 0; i < 9; i++) drive(0, '0, 1, 0);
`ifdef SYNC_FIFO_HWM_EN
        exp_hwm9 = 5'd9;
`else
        exp_hwm9 = 5'd0;
`endif
        chk("hwm_numel", 64'(numel_f), 64'd0);
        chk("hwm_9", 64'(hwm_f), 64'(exp_hwm9));
        for (int i = 0; i < 5; i++) drive(1, 64'h400 + DW'(i), 0, 0);
        rst = 1'b1;
        drive(1, 64'h4FF, 0, 0);
        rst = 1'b0;
        chk("midrst_numel", 64'(numel_f), 64'd0);
        chk("midrst_hwm", 64'(hwm_r), 64'd0);
        chk("midrst_empty", 64'(empty_r), 64'd1);
        drive(0, '0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
